// File: rtl/dot_product_engine_if.sv
// Handshake bundle for dot_product_engine: job setup, operand stream
// and result channel.
interface dot_product_engine_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 2,
  parameter int ACC_W      = 24,
  parameter int SHW        = 3
);
  logic                        start;
  logic [7:0]                  len;
  logic                        signed_mode;
  logic [SHW-1:0]              shift_cnt;
  logic                        in_valid;
  logic                        in_ready;
  logic [LANES*DATA_WIDTH-1:0] a_in;
  logic [LANES*DATA_WIDTH-1:0] b_in;
  logic                        out_valid;
  logic                        out_ready;
  logic [ACC_W-1:0]            acc_out;
  logic [DATA_WIDTH-1:0]       data_out;
  logic                        ovf;
  logic                        busy;

  modport master (
    output start, len, signed_mode, shift_cnt,
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, acc_out,
    input  data_out, ovf, busy
  );

  modport slave (
    input  start, len, signed_mode, shift_cnt,
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, acc_out,
    output data_out, ovf, busy
  );
endinterface

// File: rtl/dot_product_engine.sv
// Two-stage multiply/accumulate dot product over a streamed job,
// with shifted and saturated narrow result.
module dot_product_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 2,
  parameter int ACC_W      = 24,
  parameter int SHW        = 3
) (
  input logic                 clk,
  input logic                 rst,
  dot_product_engine_if.slave bus
);
  localparam int PW = 2*DATA_WIDTH + $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE, RUN, DRAIN, DONE
  } state_t;

  state_t state_q, state_d;

  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic                  mode_q;
  logic [SHW-1:0]        shift_q;
  logic                  s1_valid;
  logic [PW-1:0]         s1_sum;
  logic [ACC_W-1:0]      acc_q;
  logic                  ovf_q;

  logic                  go;
  logic                  accept;
  logic                  last;
  logic [PW-1:0]         lane_sum;
  logic [ACC_W-1:0]      s1_ext;
  logic [ACC_W-1:0]      acc_sum;
  logic                  carry;
  logic                  ovf_now;
  logic [ACC_W-1:0]      shifted;
  logic [DATA_WIDTH-1:0] sat;

  function automatic logic [PW-1:0] ext_op(
    input logic [DATA_WIDTH-1:0] v,
    input logic                  s
  );
    if (s) ext_op = PW'($signed(v));
    else   ext_op = PW'(v);
  endfunction

  assign go     = (state_q == IDLE) && bus.start;
  assign accept = bus.in_valid && bus.in_ready;
  assign last   = (cnt_q + 8'd1) == len_q;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum +
        ext_op(bus.a_in[i*DATA_WIDTH +: DATA_WIDTH], mode_q) *
        ext_op(bus.b_in[i*DATA_WIDTH +: DATA_WIDTH], mode_q);
    end
  end

  always_comb begin
    if (mode_q) s1_ext = ACC_W'($signed(s1_sum));
    else        s1_ext = ACC_W'(s1_sum);
    {carry, acc_sum} = {1'b0, acc_q} + {1'b0, s1_ext};
    if (mode_q)
      ovf_now = (acc_q[ACC_W-1] == s1_ext[ACC_W-1]) &&
                (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);
    else
      ovf_now = carry;
  end

  always_comb begin
    if (mode_q) shifted = ACC_W'($signed(acc_q) >>> shift_q);
    else        shifted = acc_q >> shift_q;
    sat = shifted[DATA_WIDTH-1:0];
    if (mode_q) begin
      if (!(shifted[ACC_W-1:DATA_WIDTH-1] == '0 ||
            shifted[ACC_W-1:DATA_WIDTH-1] == '1))
        sat = shifted[ACC_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                               : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (|shifted[ACC_W-1:DATA_WIDTH]) begin
      sat = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.start)
               state_d = (bus.len == 8'd0) ? DRAIN : RUN;
      RUN:   if (accept && last) state_d = DRAIN;
      DRAIN: if (!s1_valid) state_d = DONE;
      DONE:  if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // An empty job pushes a zero entry through stage 1 so it sees the
  // same two-cycle start-to-result latency as the last beat of a job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      shift_q  <= '0;
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else if (go) begin
      len_q    <= bus.len;
      mode_q   <= bus.signed_mode;
      shift_q  <= bus.shift_cnt;
      cnt_q    <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      s1_valid <= (bus.len == 8'd0);
      s1_sum   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_sum <= lane_sum;
        cnt_q  <= cnt_q + 8'd1;
      end
      if (s1_valid) begin
        acc_q <= acc_sum;
        if (ovf_now) ovf_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = (state_q == RUN) && (cnt_q < len_q);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.acc_out   = acc_q;
  assign bus.data_out  = sat;
  assign bus.ovf       = ovf_q;
endmodule

// File: doc/dot_product_engine.md
DOT_PRODUCT_ENGINE -- requirements
Module: dot_product_engine

Interface
REQ-001 Parameter DATA_WIDTH, default 8, operand element width in bits.
REQ-002 Parameter LANES, default 2, element pairs multiplied and summed per accepted beat.
REQ-003 Parameter ACC_W, default 24, accumulator width; SHALL satisfy ACC_W >= 2*DATA_WIDTH + clog2(LANES).
REQ-004 Parameter SHW, default 3, width of shift_cnt.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  begin a job when IDLE; samples len, signed_mode and shift_cnt.
REQ-008 len  input  8  number of beats in the job; 0 is legal.
REQ-009 signed_mode  input  1  1 = two's-complement operands and result; 0 = unsigned.
REQ-010 shift_cnt  input  SHW  right-shift applied to the accumulator to form data_out.
REQ-011 in_valid  input  1  a_in and b_in hold a beat.
REQ-012 in_ready  output  1  engine accepts a beat this cycle.
REQ-013 a_in, b_in  input  LANES*DATA_WIDTH each  packed operands; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-014 out_valid  output  1  result is presented.
REQ-015 out_ready  input  1  consumer takes the result.
REQ-016 acc_out  output  ACC_W  full accumulator value.
REQ-017 data_out  output  DATA_WIDTH  shifted and saturated result.
REQ-018 ovf  output  1  sticky overflow flag for the current job.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-021 IDLE + start: latch len, mode and shift, clear accumulator, beat counter and ovf; go to RUN, or to DRAIN when len == 0.
REQ-022 start SHALL be ignored outside IDLE.
REQ-023 in_ready SHALL be 1 only in RUN while beat count < latched len; a beat is accepted when in_valid && in_ready.
REQ-024 Stage 1: on an accepted beat, register the sum of the LANES products (signed or unsigned per latched mode) with a valid bit.
REQ-025 Stage 2: on a valid stage-1 entry, add it to the accumulator, sign- or zero-extended to ACC_W.
REQ-026 Accumulator overflow (signed or unsigned per mode) SHALL set ovf; ovf holds until the next start or reset; the accumulator wraps modulo 2^ACC_W.
REQ-027 When the last beat is accepted, transition RUN -> DRAIN.
REQ-028 DRAIN -> DONE once stage 1 is empty; out_valid SHALL rise exactly 2 cycles after the clock edge that accepts the last beat.
REQ-029 With len == 0, out_valid SHALL rise 2 cycles after the start edge, with acc_out = 0.
REQ-030 In DONE, out_valid = 1; acc_out, data_out and ovf SHALL stay stable until out_ready.
REQ-031 DONE with out_ready = 1: go to IDLE the next cycle; a start in that same cycle SHALL be ignored.
REQ-032 data_out = acc >> shift (arithmetic in signed mode, logical in unsigned mode), saturated to the DATA_WIDTH range (signed: -2^(W-1)..2^(W-1)-1; unsigned: 0..2^W-1).
REQ-033 Bubbles (in_valid = 0 in RUN) SHALL stall without changing the beat count or the accumulator.

Reset
REQ-034 On rst: state = IDLE; in_ready, out_valid, ovf and busy = 0; acc_out, data_out, beat counter and pipeline registers = 0; all asynchronously.
REQ-035 A reset mid-job SHALL abort the job with no out_valid pulse; the next start after reset SHALL behave normally.

Verification
REQ-036 Unsigned, len = 3, shift = 0, beats (a = {2,1}, b = {3,4}) x3 -> acc_out = 30, data_out = 30, ovf = 0, out_valid 2 cycles after the 3rd accept.
REQ-037 Signed, len = 2, beats a = {-128,-128}, b = {-128,-128} -> acc_out = 65536, shift = 3 -> data_out saturates to 127.
REQ-038 Signed, len = 1, a = {-5,0}, b = {7,0}, shift = 1 -> acc_out = -35, data_out = -18 (arithmetic shift).
REQ-039 len = 0 -> out_valid 2 cycles after start, acc_out = 0; hold out_ready = 0 for 5 cycles -> outputs stable; start during DONE is ignored.
REQ-040 Random in_valid bubbles with len = 16 -> acc_out matches the reference sum, and exactly 16 beats are accepted.
REQ-041 rst asserted after 2 of 4 beats -> outputs cleared immediately and no out_valid; a following job with len = 1, a = {1,1}, b = {1,1} -> acc_out = 2.
